// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed latency for the Y86-64 memory stage
// Ports:
//    i_clk          clock, all state updates on the rising edge
//    i_reset        synchronous active-high reset; clears state and storage
//    i_req_valid    request present on i_req_write/i_req_addr/i_req_wdata
//    o_req_ready    responder can accept a request this cycle
//    i_req_write    1 = write, 0 = read
//    i_req_addr     byte address of the least significant byte of the word
//    i_req_wdata    write data (ignored on reads)
//    o_rsp_valid    one-cycle response strobe
//    o_rsp_rdata    read data, zero outside the response cycle and for writes/errors
//    o_rsp_error    address out of range, zero outside the response cycle
module dmem_responder #(
   parameter int MEM_BYTES = 1024,
   parameter int LATENCY   = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [63:0] i_req_addr,
   input  logic [63:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [63:0] o_rsp_rdata,
   output logic        o_rsp_error
);
   localparam int AW = $clog2(MEM_BYTES);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic        r_err;
   logic [AW-1:0] r_addr;
   logic [63:0] r_wdata;
   logic        r_ready;
   logic        r_rsp_valid;
   logic [63:0] r_rsp_rdata;
   logic        r_rsp_error;
   logic [7:0]  r_mem [MEM_BYTES];
   logic        w_err;
   logic        w_acc;
   logic [AW-1:0] w_src_addr;
   logic        w_src_err;
   logic        w_src_write;
   logic [63:0] w_word;
   logic [63:0] w_rsp_data;
   // Comparing against the constant limit (instead of computing A+8) cannot wrap.
   always_comb begin
      w_err       = i_req_addr > 64'(MEM_BYTES - 8);
      w_acc       = i_req_valid & r_ready;
      // With LATENCY == 1 the response is loaded on the accepting edge, so the
      // request fields come straight from the inputs; otherwise from the capture.
      w_src_addr  = (r_state == IDLE) ? i_req_addr[AW-1:0] : r_addr;
      w_src_err   = (r_state == IDLE) ? w_err : r_err;
      w_src_write = (r_state == IDLE) ? i_req_write : r_write;
      w_word      = '0;
      for (int b = 0; b < 8; b++)
         w_word[8*b +: 8] = r_mem[AW'(w_src_addr + AW'(b))];
      w_rsp_data  = (w_src_err | w_src_write) ? '0 : w_word;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_err       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
         for (int i = 0; i < MEM_BYTES; i++)
            r_mem[AW'(i)] <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_acc) begin
               r_write <= i_req_write;
               r_err   <= w_err;
               r_addr  <= i_req_addr[AW-1:0];
               r_wdata <= i_req_wdata;
               r_ready <= 1'b0;
               if (LATENCY == 1) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_rsp_data;
                  r_rsp_error <= w_err;
               end else begin
                  r_state <= WAIT;
                  r_cnt   <= 4'(LATENCY - 2);
               end
            end
            WAIT: if (r_cnt == 4'd0) begin
               r_state     <= RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= w_rsp_data;
               r_rsp_error <= r_err;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: begin
               r_state     <= IDLE;
               r_ready     <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= '0;
               r_rsp_error <= 1'b0;
               // Writes land on the edge closing the response cycle.
               if (r_write && !r_err)
                  for (int b = 0; b < 8; b++)
                     r_mem[AW'(r_addr + AW'(b))] <= r_wdata[8*b +: 8];
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_req_ready = r_ready;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_error = r_rsp_error;
endmodule
